// File: rtl/standoff_round_sequencer.sv
// Round sequencer for the two-player standoff: countdown, action capture, resolution, winner.
// Latency: every output is registered; a round resolves one cycle after the final capture tick.
// Backpressure: none; i_pause holds all state, and i_tick paces the countdown and capture phases.
module standoff_round_sequencer #(
   parameter int MAX_BULLETS   = 3,
   parameter int START_BULLETS = 1,
   parameter int COUNT_START   = 3,
   parameter int CAPTURE_TICKS = 2
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_tick,
   input  logic       i_pause,
   input  logic       i_load,
   input  logic       i_p1_valid,
   input  logic [1:0] i_p1_action,
   input  logic       i_p2_valid,
   input  logic [1:0] i_p2_action,
   output logic [2:0] o_p1_bullets,
   output logic [2:0] o_p2_bullets,
   output logic [6:0] o_countdown,
   output logic [2:0] o_phase,
   output logic [1:0] o_winner,
   output logic       o_round_done,
   output logic       o_game_over
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_COUNTDOWN = 3'd1;
   localparam logic [2:0] ST_CAPTURE   = 3'd2;
   localparam logic [2:0] ST_RESOLVE   = 3'd3;
   localparam logic [2:0] ST_SHOW      = 3'd4;
   localparam logic [2:0] ST_OVER      = 3'd5;

   localparam logic [1:0] ACT_NONE   = 2'b00;
   localparam logic [1:0] ACT_SHOOT  = 2'b01;
   localparam logic [1:0] ACT_RELOAD = 2'b10;
   localparam logic [1:0] ACT_DUCK   = 2'b11;

   localparam int         CW        = $clog2(CAPTURE_TICKS + 1);
   localparam logic [2:0] START_B   = 3'(START_BULLETS);
   localparam logic [2:0] MAX_B     = 3'(MAX_BULLETS);
   localparam logic [6:0] CD_START  = 7'(COUNT_START);
   localparam logic [CW-1:0] CAP_START = CW'(CAPTURE_TICKS);

   logic [2:0]    r_state;
   logic [2:0]    w_state_nxt;
   logic [6:0]    r_countdown;
   logic [CW-1:0] r_cap_cnt;
   logic [2:0]    r_p1_b;
   logic [2:0]    r_p2_b;
   logic [1:0]    r_winner;
   logic          r_round_done;
   logic          r_game_over;
   logic [1:0]    r_p1_act;
   logic [1:0]    r_p2_act;
   logic          r_p1_got;
   logic          r_p2_got;

   logic          w_p1_eff;
   logic          w_p2_eff;
   logic          w_p1_hit;
   logic          w_p2_hit;
   logic [2:0]    w_p1_b_res;
   logic [2:0]    w_p2_b_res;
   logic [1:0]    w_winner_res;

   // State register
   always_ff @(posedge i_clk) begin
      if (i_reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next-state logic; pause holds the current state
   always_comb begin
      w_state_nxt = r_state;
      if (!i_pause) begin
         case (r_state)
            ST_IDLE, ST_OVER: if (i_load) w_state_nxt = ST_COUNTDOWN;
            ST_COUNTDOWN:     if (i_tick && r_countdown == 7'd1) w_state_nxt = ST_CAPTURE;
            ST_CAPTURE:       if (i_tick && r_cap_cnt == CW'(1)) w_state_nxt = ST_RESOLVE;
            ST_RESOLVE:       w_state_nxt = ST_SHOW;
            ST_SHOW:          w_state_nxt = (r_winner != 2'b00) ? ST_OVER : ST_COUNTDOWN;
            default:          w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Round resolution from the latched actions and the pre-round bullet counts
   always_comb begin
      w_p1_eff = (r_p1_act == ACT_SHOOT) && (r_p1_b != 3'd0);
      w_p2_eff = (r_p2_act == ACT_SHOOT) && (r_p2_b != 3'd0);
      // Ducking or firing back protects a player; a dry shot does not
      w_p1_hit = w_p2_eff && (r_p1_act != ACT_DUCK) && !w_p1_eff;
      w_p2_hit = w_p1_eff && (r_p2_act != ACT_DUCK) && !w_p2_eff;
      w_p1_b_res = r_p1_b;
      if (w_p1_eff)
         w_p1_b_res = r_p1_b - 3'd1;
      else if (r_p1_act == ACT_RELOAD)
         w_p1_b_res = (r_p1_b >= MAX_B) ? MAX_B : r_p1_b + 3'd1;
      w_p2_b_res = r_p2_b;
      if (w_p2_eff)
         w_p2_b_res = r_p2_b - 3'd1;
      else if (r_p2_act == ACT_RELOAD)
         w_p2_b_res = (r_p2_b >= MAX_B) ? MAX_B : r_p2_b + 3'd1;
      w_winner_res = 2'b00;
      if (w_p1_hit && !w_p2_hit)
         w_winner_res = 2'b10;
      else if (w_p2_hit && !w_p1_hit)
         w_winner_res = 2'b01;
   end

   // Counters, action latches, bullet counts and status flags
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_countdown  <= 7'd0;
         r_cap_cnt    <= '0;
         r_p1_b       <= START_B;
         r_p2_b       <= START_B;
         r_winner     <= 2'b00;
         r_round_done <= 1'b0;
         r_game_over  <= 1'b0;
         r_p1_act     <= ACT_NONE;
         r_p2_act     <= ACT_NONE;
         r_p1_got     <= 1'b0;
         r_p2_got     <= 1'b0;
      end else if (!i_pause) begin
         case (r_state)
            ST_IDLE, ST_OVER: begin
               if (i_load) begin
                  r_countdown <= CD_START;
                  r_p1_b      <= START_B;
                  r_p2_b      <= START_B;
                  r_winner    <= 2'b00;
               end
            end
            ST_COUNTDOWN: begin
               if (i_tick && r_countdown != 7'd0) begin
                  r_countdown <= r_countdown - 7'd1;
                  if (r_countdown == 7'd1) begin
                     r_cap_cnt <= CAP_START;
                     r_p1_act  <= ACT_NONE;
                     r_p2_act  <= ACT_NONE;
                     r_p1_got  <= 1'b0;
                     r_p2_got  <= 1'b0;
                  end
               end
            end
            ST_CAPTURE: begin
               // First strobe per player wins, including one on the final tick
               if (i_p1_valid && !r_p1_got) begin
                  r_p1_act <= i_p1_action;
                  r_p1_got <= 1'b1;
               end
               if (i_p2_valid && !r_p2_got) begin
                  r_p2_act <= i_p2_action;
                  r_p2_got <= 1'b1;
               end
               if (i_tick && r_cap_cnt != '0)
                  r_cap_cnt <= r_cap_cnt - CW'(1);
            end
            ST_RESOLVE: begin
               r_p1_b   <= w_p1_b_res;
               r_p2_b   <= w_p2_b_res;
               r_winner <= w_winner_res;
            end
            ST_SHOW: begin
               if (r_winner == 2'b00)
                  r_countdown <= CD_START;
            end
            default: ;
         endcase
         r_round_done <= (w_state_nxt == ST_SHOW);
         r_game_over  <= (w_state_nxt == ST_OVER);
      end
   end

   // Outputs come straight from registers
   always_comb begin
      o_p1_bullets = r_p1_b;
      o_p2_bullets = r_p2_b;
      o_countdown  = r_countdown;
      o_phase      = r_state;
      o_winner     = r_winner;
      o_round_done = r_round_done;
      o_game_over  = r_game_over;
   end

endmodule

// File: tb/tb_standoff_round_sequencer.sv
// Directed bench for the standoff sequencer; round outcomes go through an expected-result queue.
// Latency: one result per round, compared when the round_done pulse appears.
// Backpressure: none; every wait on the design is bounded by a cycle budget.
module tb_standoff_round_sequencer;

   typedef struct packed {
      logic [1:0] winner;
      logic [2:0] p1_b;
      logic [2:0] p2_b;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tick = 1'b0;
   logic       pause = 1'b0;
   logic       load = 1'b0;
   logic       p1_valid = 1'b0;
   logic [1:0] p1_action = 2'b00;
   logic       p2_valid = 1'b0;
   logic [1:0] p2_action = 2'b00;
   logic [2:0] p1_bullets;
   logic [2:0] p2_bullets;
   logic [6:0] countdown;
   logic [2:0] phase;
   logic [1:0] winner;
   logic       round_done;
   logic       game_over;

   int   n_assert = 0;
   int   n_fail = 0;
   exp_t sb_q[$];

   standoff_round_sequencer dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_tick       (tick),
      .i_pause      (pause),
      .i_load       (load),
      .i_p1_valid   (p1_valid),
      .i_p1_action  (p1_action),
      .i_p2_valid   (p2_valid),
      .i_p2_action  (p2_action),
      .o_p1_bullets (p1_bullets),
      .o_p2_bullets (p2_bullets),
      .o_countdown  (countdown),
      .o_phase      (phase),
      .o_winner     (winner),
      .o_round_done (round_done),
      .o_game_over  (game_over)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic strobe(input logic v1, input logic [1:0] a1, input logic v2, input logic [1:0] a2);
      p1_valid = v1; p1_action = a1;
      p2_valid = v2; p2_action = a2;
      step();
      p1_valid = 1'b0; p2_valid = 1'b0;
   endtask

   task automatic to_capture();
      for (int i = 0; i < 3; i++) do_tick();
   endtask

   // Wait (bounded) for the round_done pulse, pop the expected result, then step past SHOW
   task automatic wait_round(input string tag);
      exp_t e;
      for (int i = 0; i < 20; i++) begin
         if (round_done) break;
         step();
      end
      chk({tag, "_round_done"}, 8'(round_done), 8'd1);
      chk({tag, "_sb_nonempty"}, 8'(sb_q.size() != 0), 8'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk({tag, "_winner"}, 8'(winner), 8'(e.winner));
         chk({tag, "_p1_bullets"}, 8'(p1_bullets), 8'(e.p1_b));
         chk({tag, "_p2_bullets"}, 8'(p2_bullets), 8'(e.p2_b));
      end
      step();
      chk({tag, "_pulse_end"}, 8'(round_done), 8'd0);
   endtask

   task automatic run_round(input string tag, input logic [1:0] a1, input logic [1:0] a2,
                            input logic [1:0] ew, input logic [2:0] e1, input logic [2:0] e2);
      to_capture();
      strobe(1'b1, a1, 1'b1, a2);
      sb_q.push_back('{winner: ew, p1_b: e1, p2_b: e2});
      do_tick();
      do_tick();
      wait_round(tag);
   endtask

   initial begin
      // Reset values
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      chk("rst_phase", 8'(phase), 8'd0);
      chk("rst_p1", 8'(p1_bullets), 8'd1);
      chk("rst_p2", 8'(p2_bullets), 8'd1);
      chk("rst_cd", 8'(countdown), 8'd0);
      chk("rst_winner", 8'(winner), 8'd0);
      chk("rst_done", 8'(round_done), 8'd0);
      chk("rst_over", 8'(game_over), 8'd0);

      // Load and count down 3 -> 0
      load = 1'b1; step(); load = 1'b0;
      chk("load_phase", 8'(phase), 8'd1);
      chk("load_cd", 8'(countdown), 8'd3);
      do_tick(); chk("cd2", 8'(countdown), 8'd2);
      do_tick(); chk("cd1", 8'(countdown), 8'd1); chk("cd1_phase", 8'(phase), 8'd1);
      do_tick(); chk("cd0", 8'(countdown), 8'd0); chk("cap_phase", 8'(phase), 8'd2);
      chk("cap_p1", 8'(p1_bullets), 8'd1);
      chk("cap_p2", 8'(p2_bullets), 8'd1);

      // P1 shoots, P2 reloads: P1 wins
      strobe(1'b1, 2'b01, 1'b1, 2'b10);
      sb_q.push_back('{winner: 2'b01, p1_b: 3'd0, p2_b: 3'd2});
      do_tick(); chk("cap_hold", 8'(phase), 8'd2);
      do_tick(); chk("resolve_phase", 8'(phase), 8'd3);
      step();
      chk("show_phase", 8'(phase), 8'd4);
      wait_round("r1");
      chk("r1_over_phase", 8'(phase), 8'd5);
      chk("r1_game_over", 8'(game_over), 8'd1);
      step();
      chk("r1_over_hold", 8'(winner), 8'd1);

      // Restart from OVER; P1 shoots, P2 ducks: no winner
      load = 1'b1; step(); load = 1'b0;
      chk("reload_phase", 8'(phase), 8'd1);
      chk("reload_p1", 8'(p1_bullets), 8'd1);
      chk("reload_winner", 8'(winner), 8'd0);
      chk("reload_over", 8'(game_over), 8'd0);
      run_round("r2", 2'b01, 2'b11, 2'b00, 3'd0, 3'd1);
      chk("r2_phase", 8'(phase), 8'd1);
      chk("r2_cd", 8'(countdown), 8'd3);

      // P1 dry shot, P2 shoots: P2 wins
      run_round("r3", 2'b01, 2'b01, 2'b10, 3'd0, 3'd0);
      chk("r3_over", 8'(game_over), 8'd1);

      // Both shoot with one bullet each: draw
      load = 1'b1; step(); load = 1'b0;
      run_round("r4", 2'b01, 2'b01, 2'b00, 3'd0, 3'd0);
      chk("r4_phase", 8'(phase), 8'd1);

      // Reload saturation at 3
      run_round("r5", 2'b10, 2'b11, 2'b00, 3'd1, 3'd0);
      run_round("r6", 2'b10, 2'b11, 2'b00, 3'd2, 3'd0);
      run_round("r7", 2'b10, 2'b11, 2'b00, 3'd3, 3'd0);
      run_round("r8", 2'b10, 2'b11, 2'b00, 3'd3, 3'd0);

      // Pause mid-countdown; load is ignored in COUNTDOWN
      do_tick(); chk("p_cd2", 8'(countdown), 8'd2);
      load = 1'b1; step(); load = 1'b0;
      chk("cd_load_ignored", 8'(countdown), 8'd2);
      pause = 1'b1;
      for (int i = 0; i < 5; i++) do_tick();
      chk("pause_cd", 8'(countdown), 8'd2);
      chk("pause_cd_phase", 8'(phase), 8'd1);
      pause = 1'b0;
      do_tick(); do_tick();
      chk("resume_cd", 8'(countdown), 8'd0);
      chk("resume_phase", 8'(phase), 8'd2);

      // Pause mid-capture: counter frozen, strobe during pause dropped
      pause = 1'b1;
      strobe(1'b1, 2'b01, 1'b0, 2'b00);
      for (int i = 0; i < 5; i++) do_tick();
      chk("pause_cap_phase", 8'(phase), 8'd2);
      pause = 1'b0;
      do_tick(); chk("cap_resume_phase", 8'(phase), 8'd2);
      strobe(1'b1, 2'b10, 1'b1, 2'b11);
      sb_q.push_back('{winner: 2'b00, p1_b: 3'd3, p2_b: 3'd0});
      do_tick(); chk("cap_resume_resolve", 8'(phase), 8'd3);
      wait_round("r9");

      // Double strobe keeps the first; strobe on the final tick is latched
      to_capture();
      strobe(1'b1, 2'b10, 1'b0, 2'b00);
      strobe(1'b1, 2'b01, 1'b0, 2'b00);
      do_tick();
      sb_q.push_back('{winner: 2'b00, p1_b: 3'd3, p2_b: 3'd1});
      p2_valid = 1'b1; p2_action = 2'b10;
      do_tick();
      p2_valid = 1'b0;
      wait_round("r10");

      // Reset during CAPTURE
      to_capture();
      strobe(1'b1, 2'b01, 1'b0, 2'b00);
      reset = 1'b1; step(); reset = 1'b0;
      chk("mid_rst_phase", 8'(phase), 8'd0);
      chk("mid_rst_p1", 8'(p1_bullets), 8'd1);
      chk("mid_rst_p2", 8'(p2_bullets), 8'd1);
      chk("mid_rst_cd", 8'(countdown), 8'd0);
      step();
      chk("mid_rst_idle", 8'(phase), 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
